// File: rtl/bus_trace_buffer_pkg.sv
// Shared definitions for the bus trace buffer: default IO window base, capture kinds
// and the entry-width helper used to size the trace RAM.
package bus_trace_buffer_pkg;

   localparam logic [31:0] IO_BASE = 32'hFFFF0000;

   typedef enum logic [1:0] {
      CAP_NONE  = 2'd0,
      CAP_READ  = 2'd1,
      CAP_WRITE = 2'd2
   } cap_kind_e;

   // Entry layout, MSB first: {is_write, ts, addr, data}
   function automatic int entry_width(input int ts_w, input int addr_w, input int data_w);
      return 1 + ts_w + addr_w + data_w;
   endfunction

endpackage

// File: rtl/bus_trace_buffer_trace_ram.sv
// Simple dual-port trace RAM: synchronous write, registered synchronous read.
// A read and write to the same address on one edge returns the old contents.
module trace_ram #(
   parameter int WIDTH = 81,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   // Output register holds its value between reads so the host sees a stable entry
   always_ff @(posedge clk) begin
      if (reset)
         rdata <= '0;
      else if (re)
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/bus_trace_buffer.sv
// In-system bus trace buffer: filters CPU bus transactions by address window, timestamps
// them into a circular trace RAM, and flags a stalled CPU through a sticky watchdog.
module bus_trace_buffer
   import bus_trace_buffer_pkg::*;
#(
   parameter int          ADDR_W    = 32,
   parameter int          DATA_W    = 32,
   parameter int          DEPTH     = 64,
   parameter int          TS_W      = 16,
   parameter bit          CAP_READS = 1'b0,
   parameter bit          WRAP      = 1'b1,
   parameter logic [31:0] FILT_LO   = IO_BASE,
   parameter logic [31:0] FILT_HI   = 32'hFFFFFFFF,
   parameter int          WD_CYCLES = 1000
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [31:0]                     adr,
   input  logic [31:0]                     writedata,
   input  logic [31:0]                     memdata,
   input  logic                            memread,
   input  logic                            memwrite,
   input  logic                            pop,
   output logic [TS_W+ADDR_W+DATA_W:0]     pop_data,
   output logic                            pop_valid,
   output logic [$clog2(DEPTH):0]          count,
   output logic                            empty,
   output logic                            full,
   output logic                            overflow,
   input  logic                            wd_clear,
   output logic                            wd_expired
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = entry_width(TS_W, ADDR_W, DATA_W);
   localparam int WD_W    = $clog2(WD_CYCLES + 1);

   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [TS_W-1:0]    ts;
   logic [WD_W-1:0]    wd_cnt;
   cap_kind_e          kind;
   logic               in_window;
   logic               capture;
   logic               pop_ok;
   logic               push_ok;
   logic               overwrite;
   logic               rd_adv;
   logic               lost;
   logic [ENTRY_W-1:0] wr_entry;

   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));

   // A full buffer still accepts a capture when a pop frees the oldest slot on the same edge
   always_comb begin
      in_window = (adr >= FILT_LO) && (adr <= FILT_HI);
      kind      = CAP_NONE;
      if (in_window && memwrite)
         kind = CAP_WRITE;
      else if (in_window && CAP_READS && memread)
         kind = CAP_READ;
      capture   = (kind != CAP_NONE);
      pop_ok    = pop && !empty;
      push_ok   = capture && (!full || pop_ok || WRAP);
      overwrite = capture && full && !pop_ok && WRAP;
      rd_adv    = pop_ok || overwrite;
      lost      = capture && full && !pop_ok;
      wr_entry  = {kind == CAP_WRITE, ts, adr[ADDR_W-1:0],
                   (kind == CAP_WRITE) ? writedata[DATA_W-1:0] : memdata[DATA_W-1:0]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         ts         <= '0;
         pop_valid  <= 1'b0;
         overflow   <= 1'b0;
         wd_cnt     <= '0;
         wd_expired <= 1'b0;
      end else begin
         ts        <= ts + TS_W'(1);
         pop_valid <= pop_ok;
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_adv)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (push_ok && !rd_adv)
            count <= count + CNT_W'(1);
         else if (rd_adv && !push_ok)
            count <= count - CNT_W'(1);
         if (lost)
            overflow <= 1'b1;

         // Watchdog saturates; clearing wins over a coincident expiry
         if (wd_clear || capture)
            wd_cnt <= '0;
         else if (wd_cnt != WD_W'(WD_CYCLES))
            wd_cnt <= wd_cnt + WD_W'(1);
         if (wd_clear)
            wd_expired <= 1'b0;
         else if (!capture && wd_cnt >= WD_W'(WD_CYCLES - 1))
            wd_expired <= 1'b1;
      end
   end

   trace_ram #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_trace_ram (
      .clk   (clk),
      .reset (reset),
      .we    (push_ok),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .re    (pop_ok),
      .raddr (rd_ptr),
      .rdata (pop_data)
   );

endmodule

// File: tb/tb_bus_trace_buffer.sv
// Directed bench for bus_trace_buffer: a wrapping, a dropping and a read-capturing
// instance share the bus so each directed vector exercises all three modes.
module tb_bus_trace_buffer;

   logic        clk;
   logic        reset;
   logic [31:0] adr;
   logic [31:0] writedata;
   logic [31:0] memdata;
   logic        memread;
   logic        memread_r;
   logic        memwrite;
   logic        pop;
   logic        wd_clear;

   logic [80:0] pop_data_a, pop_data_b, pop_data_r;
   logic        pop_valid_a, pop_valid_b, pop_valid_r;
   logic [2:0]  count_a, count_b;
   logic [3:0]  count_r;
   logic        empty_a, empty_b, empty_r;
   logic        full_a, full_b, full_r;
   logic        overflow_a, overflow_b, overflow_r;
   logic        wd_expired_a, wd_expired_b, wd_expired_r;

   int tests_run;
   int tests_failed;

   bus_trace_buffer #(.DEPTH(4), .WRAP(1'b1), .CAP_READS(1'b0), .WD_CYCLES(10)) dut_a (
      .clk(clk), .reset(reset), .adr(adr), .writedata(writedata), .memdata(memdata),
      .memread(memread), .memwrite(memwrite), .pop(pop), .pop_data(pop_data_a),
      .pop_valid(pop_valid_a), .count(count_a), .empty(empty_a), .full(full_a),
      .overflow(overflow_a), .wd_clear(wd_clear), .wd_expired(wd_expired_a)
   );

   bus_trace_buffer #(.DEPTH(4), .WRAP(1'b0), .CAP_READS(1'b0), .WD_CYCLES(10)) dut_b (
      .clk(clk), .reset(reset), .adr(adr), .writedata(writedata), .memdata(memdata),
      .memread(memread), .memwrite(memwrite), .pop(pop), .pop_data(pop_data_b),
      .pop_valid(pop_valid_b), .count(count_b), .empty(empty_b), .full(full_b),
      .overflow(overflow_b), .wd_clear(wd_clear), .wd_expired(wd_expired_b)
   );

   bus_trace_buffer #(.DEPTH(8), .WRAP(1'b1), .CAP_READS(1'b1), .WD_CYCLES(10)) dut_r (
      .clk(clk), .reset(reset), .adr(adr), .writedata(writedata), .memdata(memdata),
      .memread(memread_r), .memwrite(memwrite), .pop(pop), .pop_data(pop_data_r),
      .pop_valid(pop_valid_r), .count(count_r), .empty(empty_r), .full(full_r),
      .overflow(overflow_r), .wd_clear(wd_clear), .wd_expired(wd_expired_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Drives one bus cycle, lets it be sampled, then returns strobes to idle
   task automatic applyStimulus(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                input logic rd, input logic rd_r, input logic [31:0] md,
                                input logic p, input logic clr);
      memwrite  = we;
      adr       = a;
      writedata = wd;
      memread   = rd;
      memread_r = rd_r;
      memdata   = md;
      pop       = p;
      wd_clear  = clr;
      @(posedge clk);
      #1;
      memwrite  = 1'b0;
      memread   = 1'b0;
      memread_r = 1'b0;
      pop       = 1'b0;
      wd_clear  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++)
         applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   logic [31:0] wr_addr [6];
   logic [31:0] exp_a   [4];
   logic [31:0] exp_b   [4];

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      wr_addr = '{32'hFFFF0000, 32'hFFFF0008, 32'hFFFF000C, 32'hFFFF0010, 32'hFFFF0014, 32'hFFFFFFFF};
      exp_a   = '{32'd3, 32'd4, 32'd5, 32'd6};
      exp_b   = '{32'd1, 32'd2, 32'd3, 32'd4};
      reset = 1'b1;
      adr = '0; writedata = '0; memdata = '0;
      memread = 1'b0; memread_r = 1'b0; memwrite = 1'b0; pop = 1'b0; wd_clear = 1'b0;
      idle(2);
      reset = 1'b0;

      checkOutput("reset_count", count_a, 0);
      checkOutput("reset_empty", empty_a, 1);
      checkOutput("reset_pop_valid", pop_valid_a, 0);
      checkOutput("reset_pop_data", pop_data_a, 0);
      checkOutput("reset_overflow", overflow_a, 0);
      checkOutput("reset_wd", wd_expired_a, 0);

      // Out-of-window write and an uncaptured read must leave the buffer empty
      idle(1);
      applyStimulus(1'b1, 32'h0000_0100, 32'hDEAD, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'hFFFF_0000, 32'h0, 1'b1, 1'b0, 32'h77, 1'b0, 1'b0);
      idle(6);
      checkOutput("filter_count_a", count_a, 0);
      checkOutput("filter_count_b", count_b, 0);
      checkOutput("wd_before_10_a", wd_expired_a, 0);
      checkOutput("wd_before_10_b", wd_expired_b, 0);
      idle(1);
      checkOutput("wd_at_10_a", wd_expired_a, 1);
      checkOutput("wd_at_10_b", wd_expired_b, 1);
      checkOutput("wd_at_10_r", wd_expired_r, 1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("wd_clear_a", wd_expired_a, 0);
      checkOutput("wd_clear_r", wd_expired_r, 0);

      applyStimulus(1'b1, 32'hFFFF_0004, 32'h0000_00A5, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("first_write_count", count_a, 1);
      checkOutput("first_write_empty", empty_a, 0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("first_pop_valid", pop_valid_a, 1);
      checkOutput("first_pop_data", pop_data_a, {1'b1, 16'd11, 32'hFFFF_0004, 32'h0000_00A5});
      checkOutput("first_pop_count", count_a, 0);
      idle(1);
      checkOutput("pop_valid_pulse", pop_valid_a, 0);
      checkOutput("pop_data_held", pop_data_a, {1'b1, 16'd11, 32'hFFFF_0004, 32'h0000_00A5});
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("pop_empty_valid", pop_valid_a, 0);
      checkOutput("pop_empty_count", count_a, 0);

      applyStimulus(1'b0, 32'hFFFF_0010, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
      checkOutput("read_cap_count_r", count_r, 1);
      checkOutput("read_nocap_count_a", count_a, 0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("read_pop_valid_r", pop_valid_r, 1);
      checkOutput("read_pop_data_r", pop_data_r, {1'b0, 16'd15, 32'hFFFF_0010, 32'h1234_5678});

      // Six writes spaced five cycles apart keep the watchdog quiet
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, wr_addr[i], 32'(i + 1), 1'b0, (i == 0), 32'hBAD, 1'b0, 1'b0);
         if (i == 2) begin
            idle(1);
            applyStimulus(1'b1, 32'hFFFE_FFFC, 32'h99, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            idle(2);
         end else if (i < 5) begin
            idle(4);
         end
      end
      checkOutput("fill_count_a", count_a, 4);
      checkOutput("fill_full_a", full_a, 1);
      checkOutput("fill_overflow_a", overflow_a, 1);
      checkOutput("fill_count_b", count_b, 4);
      checkOutput("fill_overflow_b", overflow_b, 1);
      checkOutput("fill_count_r", count_r, 6);
      checkOutput("fill_overflow_r", overflow_r, 0);
      checkOutput("fill_wd_a", wd_expired_a, 0);

      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
         checkOutput($sformatf("drain_valid_a_%0d", i), pop_valid_a, 1);
         checkOutput($sformatf("drain_data_a_%0d", i), pop_data_a[31:0], exp_a[i]);
         checkOutput($sformatf("drain_data_b_%0d", i), pop_data_b[31:0], exp_b[i]);
         checkOutput($sformatf("drain_data_r_%0d", i), pop_data_r[31:0], exp_b[i]);
      end
      checkOutput("drain_iswrite_r", pop_data_r[80], 1);
      checkOutput("drain_empty_a", empty_a, 1);
      checkOutput("drain_empty_b", empty_b, 1);
      checkOutput("drain_count_r", count_r, 2);

      for (int i = 7; i <= 9; i++)
         applyStimulus(1'b1, 32'hFFFF_0100, 32'(i), 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("pre_reset_count_a", count_a, 3);
      reset = 1'b1;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      reset = 1'b0;
      checkOutput("midreset_count_a", count_a, 0);
      checkOutput("midreset_pop_valid_a", pop_valid_a, 0);
      checkOutput("midreset_overflow_a", overflow_a, 0);
      checkOutput("midreset_overflow_b", overflow_b, 0);
      checkOutput("midreset_pop_data_a", pop_data_a, 0);

      for (int i = 11; i <= 14; i++)
         applyStimulus(1'b1, 32'hFFFF_0200, 32'(i), 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("refill_full_a", full_a, 1);
      checkOutput("refill_full_b", full_b, 1);
      applyStimulus(1'b1, 32'hFFFF_0200, 32'd15, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("cap_pop_full_count_a", count_a, 4);
      checkOutput("cap_pop_full_count_b", count_b, 4);
      checkOutput("cap_pop_full_ovf_a", overflow_a, 0);
      checkOutput("cap_pop_full_ovf_b", overflow_b, 0);
      checkOutput("cap_pop_full_data_a", pop_data_a, {1'b1, 16'd0, 32'hFFFF_0200, 32'd11});
      checkOutput("cap_pop_full_data_b", pop_data_b[31:0], 11);
      checkOutput("cap_pop_count_r", count_r, 4);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
